// File: rtl/serial_add_sequencer.sv
// Bit-serial add controller: feeds operands LSB-first to an external 1-bit full adder,
// collects the returned sum bits and carry, and hands {carry_out,result} downstream.
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry_q;
  logic [CW-1:0]    bit_cnt;

  // Handshake and adder drive are decoded from registered state only.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign fa_a      = (state == RUN) & a_sh[0];
  assign fa_b      = (state == RUN) & b_sh[0];
  assign fa_cin    = (state == RUN) & carry_q;

  // Sequencer FSM and datapath; result/carry_out are loaded on the last bit and held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      carry_q   <= 1'b0;
      bit_cnt   <= '0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh    <= op_a;
            b_sh    <= op_b;
            carry_q <= op_cin;
            bit_cnt <= '0;
            res_sh  <= '0;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          res_sh  <= {fa_sum, res_sh[WIDTH-1:1]};
          carry_q <= fa_cout;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          if (bit_cnt == LAST_BIT) begin
            result    <= {fa_sum, res_sh[WIDTH-1:1]};
            carry_out <= fa_cout;
            state     <= DONE;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end else begin
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed + random bench: real full adder on the fa_* ports, scoreboard queue of
// expected {carry,result} pushed at accept and popped at output handshake.
module tb_serial_add_sequencer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_sum;
  logic             fa_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;

  int   passed    = 0;
  int   total     = 0;
  int   cyc       = 0;
  int   acc_count = 0;
  int   acc_edge  = -1;
  int   b2b_acc   = 0;
  bit   b2b       = 1'b0;
  logic prev_ov   = 1'b0;
  logic [WIDTH:0] exp_q[$];

  always #5 clk = ~clk;

  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  serial_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_sum(fa_sum), .fa_cout(fa_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampled on the falling edge ahead of the edge that acts.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_ov)
        check("latency_edges_incl_accept", 64'(cyc - acc_edge + 1), 64'(WIDTH + 1));
      if (in_valid && in_ready) begin
        if (b2b && b2b_acc > 0)
          check("accept_interval", 64'(cyc + 1 - acc_edge), 64'(WIDTH + 2));
        if (b2b) b2b_acc++;
        acc_edge = cyc + 1;
        acc_count++;
        exp_q.push_back({1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_cin});
      end
      if (out_valid && out_ready) begin
        check("sb_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0)
          check("sb_sum", 64'({carry_out, result}), 64'(exp_q.pop_front()));
      end
    end
    prev_ov = out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    check("done_timeout", 64'(out_valid), 64'd1);
  endtask

  // Offers one operand set from IDLE, checks first-bit drive, waits for DONE and checks result.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] er, input logic ec);
    op_a = a; op_b = b; op_cin = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("fa_bit0", 64'({fa_a, fa_b, fa_cin}), 64'({a[0], b[0], c}));
    check("in_ready_busy", 64'(in_ready), 64'd0);
    wait_done();
    check("result", 64'(result), 64'(er));
    check("carry_out", 64'(carry_out), 64'(ec));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'({carry_out, result}), 64'd0);
    check("rst_fa", 64'({fa_a, fa_b, fa_cin}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Directed sums including full carry ripple and all-ones.
    run_op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
    tick();
    check("idle_after_hs", 64'(in_ready), 64'd1);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    tick();
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    tick();
    run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    check("fa_idle", 64'({fa_a, fa_b, fa_cin}), 64'd0);

    // Backpressure: DONE held for 5 cycles.
    out_ready = 1'b0;
    run_op(8'h7E, 8'h81, 1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold", 64'({out_valid, in_ready, carry_out, result}), 64'({1'b1, 1'b0, 1'b1, 8'h00}));
    end
    out_ready = 1'b1;
    tick();
    check("bp_release", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));
    check("hold_after_hs", 64'({carry_out, result}), 64'({1'b1, 8'h00}));

    // Reset during RUN at bit 3.
    op_a = 8'h12; op_b = 8'h34; op_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_fa", 64'({fa_a, fa_b, fa_cin}), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_state", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));
    run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
    tick();

    // Back-to-back random operands with in_valid held high.
    b2b = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      int tgt;
      int n;
      op_a = 8'($urandom_range(0, 255));
      op_b = 8'($urandom_range(0, 255));
      op_cin = 1'($urandom_range(0, 1));
      tgt = acc_count + 1;
      n = 0;
      while (acc_count < tgt && n < 30) begin
        tick();
        n++;
      end
      if (acc_count < tgt) check("b2b_accept_timeout", 64'(acc_count), 64'(tgt));
    end
    in_valid = 1'b0;
    repeat (WIDTH + 4) tick();
    b2b = 1'b0;
    check("b2b_count", 64'(b2b_acc), 64'd100);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
